prbs_gen_par: RTL and testbench
===============================

PRBS_GEN_PAR -- requirements
Module: prbs_gen_par

Interface
REQ-001 SHALL have parameter Nti, default 16, parallel bits per output word.
REQ-002 SHALL have parameter Nprbs, default 7, LFSR length; polynomial fixed x^7+x^6+1.
REQ-003 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-004 SHALL have port rstb, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, run enable; low freezes generation.
REQ-006 SHALL have port load, input, 1, single-cycle seed load request.
REQ-007 SHALL have port seed, input, Nprbs, LFSR seed sampled when load=1.
REQ-008 SHALL have port inj_req, input, 1, single-cycle error-injection request.
REQ-009 SHALL have port inj_bit, input, $clog2(Nti), bit lane to corrupt.
REQ-010 SHALL have port data_out, output, Nti, registered PRBS word; data_out[0] is earliest serial bit.
REQ-011 SHALL have port valid, output, 1, high when data_out holds a new word this cycle.
REQ-012 SHALL have port inj_cnt, output, 16, count of injected errors.

Function
REQ-013 SHALL implement FSM states IDLE, SEED, RUN, HOLD.
REQ-014 IDLE -> SEED on load=1; all other IDLE inputs ignored.
REQ-015 SEED lasts exactly one cycle, writes LFSR state, then -> RUN if en=1, else HOLD.
REQ-016 RUN -> HOLD when en=0; HOLD -> RUN when en=1; load=1 in RUN or HOLD -> SEED, priority over en.
REQ-017 Serial sequence: s[0..6]=seed[0..6]; s[n]=s[n-6] XOR s[n-7] for n>=7.
REQ-018 Word k after seed SHALL be data_out[i]=s[16k+i], i=0..Nti-1; LFSR advances Nti steps per RUN cycle.
REQ-019 First word (k=0) SHALL appear with valid=1 on the cycle after SEED when en=1.
REQ-020 valid SHALL be 1 exactly in cycles a new word is presented; in HOLD, data_out holds last word, valid=0.
REQ-021 Seed of all zeros SHALL be replaced by 7'h01 to avoid lock-up.
REQ-022 Sequence period SHALL be 127 words (gcd(16,127)=1); no reseed at wrap.
REQ-023 Error injection (when compiled in): inj_req latched into a pending flag; next word with valid=1 has bit inj_bit inverted; flag clears; inj_cnt increments by 1.
REQ-024 inj_cnt SHALL saturate at 16'hFFFF.
REQ-025 inj_req while pending flag set SHALL be dropped (one injection per word max).
REQ-026 Injection SHALL corrupt only data_out; LFSR state unaffected.
REQ-027 load during pending injection SHALL clear the pending flag without counting.

Reset
REQ-028 rstb=0 SHALL asynchronously force FSM=IDLE, LFSR=7'h01, data_out=0, valid=0, inj_cnt=0, pending flag=0.
REQ-029 Reset deassertion SHALL be taken synchronously; first output requires a new load.
REQ-030 Reset mid-RUN SHALL abort the current word; no partial word with valid=1.

Configuration
REQ-031 Macro PRBS_ERR_INJ_EN SHALL compile in REQ-023..REQ-027 logic.
REQ-032 Without PRBS_ERR_INJ_EN: inj_req and inj_bit ignored, inj_cnt tied to 0, no pending flag.

Verification
REQ-033 load, seed=7'h7F, en=1 -> next cycle valid=1, data_out=16'h207F.
REQ-034 load, seed=7'h00, en=1 -> next cycle data_out=16'h6081 (seed substituted 7'h01).
REQ-035 seed=7'h7F, run 127 words -> word 127 equals word 0 (16'h207F); no earlier repeat of full 7-bit state.
REQ-036 PRBS_ERR_INJ_EN defined, seed=7'h7F, inj_req with inj_bit=3 during SEED -> first word 16'h2077, inj_cnt=1; following word error-free.
REQ-037 en dropped for 5 cycles in RUN -> valid=0, data_out frozen; resume yields next sequential word, no skip.
REQ-038 rstb pulsed low mid-RUN -> immediately data_out=0, valid=0, inj_cnt=0; outputs stay idle until load.

Source files
------------

// File: rtl/prbs_gen_par.sv
// Parallel PRBS-7 (x^7+x^6+1) generator, Nti bits per word, data_out[0] earliest.
// Define PRBS_ERR_INJ_EN to compile in single-bit error injection and its counter.
module prbs_gen_par #(
  parameter int unsigned Nti   = 16,
  parameter int unsigned Nprbs = 7
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   en,
  input  logic                   load,
  input  logic [Nprbs-1:0]       seed,
  input  logic                   inj_req,
  input  logic [$clog2(Nti)-1:0] inj_bit,
  output logic [Nti-1:0]         data_out,
  output logic                   valid,
  output logic [15:0]            inj_cnt
);

  typedef enum logic [1:0] {IDLE, SEED, RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [Nprbs-1:0] lfsr_q, lfsr_d;
  logic [Nti-1:0]   data_q, data_d;
  logic             valid_q, valid_d;
  logic [Nprbs-1:0] lfsr_nx;
  logic [Nti-1:0]   word;
  logic [Nprbs-1:0] seed_fix;
  logic             adv;
  logic             load_acc;

`ifdef PRBS_ERR_INJ_EN
  logic                   pend_q, pend_d;
  logic [$clog2(Nti)-1:0] pbit_q, pbit_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   take_req;
`endif

  // Window lfsr holds s[m..m+Nprbs-1]; each step emits s[m] and appends s[m+1]^s[m].
  always_comb begin
    lfsr_nx = lfsr_q;
    word    = '0;
    for (int unsigned i = 0; i < Nti; i++) begin
      word[i] = lfsr_nx[0];
      lfsr_nx = {lfsr_nx[1] ^ lfsr_nx[0], lfsr_nx[Nprbs-1:1]};
    end
  end

  assign seed_fix = (seed == '0) ? {{(Nprbs-1){1'b0}}, 1'b1} : seed;

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    adv      = 1'b0;
    load_acc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          load_acc = 1'b1;
          state_d  = SEED;
        end
      end
      SEED: begin
        if (en) begin
          adv     = 1'b1;
          state_d = RUN;
        end else begin
          state_d = HOLD;
        end
      end
      RUN, HOLD: begin
        if (load) begin
          load_acc = 1'b1;
          state_d  = SEED;
        end else if (en) begin
          adv     = 1'b1;
          state_d = RUN;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_acc) lfsr_d = seed_fix;
    if (adv) begin
      lfsr_d  = lfsr_nx;
      data_d  = word;
      valid_d = 1'b1;
    end

`ifdef PRBS_ERR_INJ_EN
    pend_d   = pend_q;
    pbit_d   = pbit_q;
    cnt_d    = cnt_q;
    take_req = inj_req && !pend_q && (state_q != IDLE);
    // A request arriving in the cycle a word is produced corrupts that same word.
    if (load_acc) begin
      pend_d = 1'b0;
    end else if (adv && (pend_q || take_req)) begin
      data_d[pend_q ? pbit_q : inj_bit] = ~word[pend_q ? pbit_q : inj_bit];
      pend_d = 1'b0;
      if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
    end else if (take_req) begin
      pend_d = 1'b1;
      pbit_d = inj_bit;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      lfsr_q  <= {{(Nprbs-1){1'b0}}, 1'b1};
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

`ifdef PRBS_ERR_INJ_EN
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pend_q <= 1'b0;
      pbit_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      pbit_q <= pbit_d;
      cnt_q  <= cnt_d;
    end
  end
  assign inj_cnt = cnt_q;
`else
  logic unused_inj;
  assign unused_inj = ^{inj_req, inj_bit};
  assign inj_cnt    = '0;
`endif

  assign data_out = data_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_prbs_gen_par.sv
// Directed + randomized bench for prbs_gen_par; reference words come from the
// serial recurrence s[n]=s[n-6]^s[n-7] evaluated bit by bit.
module tb_prbs_gen_par;

  logic        clk = 1'b0;
  logic        rstb;
  logic        en;
  logic        load;
  logic [6:0]  seed;
  logic        inj_req;
  logic [3:0]  inj_bit;
  logic [15:0] data_out;
  logic        valid;
  logic [15:0] inj_cnt;

  int checks   = 0;
  int failures = 0;
  int k;
  logic [6:0]  cur_seed;
  logic [15:0] last;

  prbs_gen_par #(.Nti(16), .Nprbs(7)) dut (
    .clk(clk), .rstb(rstb), .en(en), .load(load), .seed(seed),
    .inj_req(inj_req), .inj_bit(inj_bit),
    .data_out(data_out), .valid(valid), .inj_cnt(inj_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_word(input logic [6:0] sd, input int kk);
    logic s [0:2399];
    logic [6:0] eff;
    logic [15:0] w;
    eff = (sd == 7'd0) ? 7'd1 : sd;
    for (int n = 0; n < 16*kk + 16; n++)
      s[n] = (n < 7) ? eff[n] : (s[n-6] ^ s[n-7]);
    for (int i = 0; i < 16; i++) w[i] = s[16*kk + i];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [6:0] sd);
    load = 1'b1;
    seed = sd;
    tick;
    load = 1'b0;
    seed = 7'($urandom);
    cur_seed = sd;
    k = -1;
    chk("seed_cycle_valid", 32'(valid), 32'd0);
  endtask

  task automatic step(input logic e, input logic [15:0] mask, input string tag);
    en = e;
    tick;
    if (e) begin
      k++;
      last = ref_word(cur_seed, k) ^ mask;
      chk({tag, "_valid"}, 32'(valid), 32'd1);
    end else begin
      chk({tag, "_valid"}, 32'(valid), 32'd0);
    end
    chk({tag, "_data"}, 32'(data_out), 32'(last));
  endtask

  initial begin
    logic e;
    rstb = 1'b0; en = 1'b0; load = 1'b0; seed = '0; inj_req = 1'b0; inj_bit = '0;
    last = '0; k = 0; cur_seed = '0;
    tick; tick;
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_cnt", 32'(inj_cnt), 32'd0);
    rstb = 1'b1;

    // IDLE ignores en without a load
    en = 1'b1;
    repeat (3) begin
      tick;
      chk("idle_valid", 32'(valid), 32'd0);
      chk("idle_data", 32'(data_out), 32'd0);
    end

    do_load(7'h7F);
    step(1'b1, 16'h0, "w0");
    chk("w0_const", 32'(data_out), 32'h207F);
    for (int i = 1; i <= 127; i++) begin
      step(1'b1, 16'h0, "run127");
      if (i < 127) chk("no_early_repeat", 32'(data_out[6:0] == 7'h7F), 32'd0);
      else         chk("wrap_word127", 32'(data_out), 32'h207F);
    end

    repeat (5) step(1'b0, 16'h0, "hold");
    step(1'b1, 16'h0, "resume");

    do_load(7'h00);
    step(1'b1, 16'h0, "zero_seed");
    chk("zero_seed_const", 32'(data_out), 32'h6081);

    repeat (4) begin
      do_load(7'($urandom));
      repeat (40) begin
        e = ($urandom % 4) != 0;
`ifndef PRBS_ERR_INJ_EN
        inj_req = 1'($urandom);
        inj_bit = 4'($urandom);
`endif
        step(e, 16'h0, "rand");
        chk("rand_cnt", 32'(inj_cnt), 32'd0);
      end
    end
    inj_req = 1'b0;

`ifdef PRBS_ERR_INJ_EN
    do_load(7'h7F);
    inj_req = 1'b1; inj_bit = 4'd3;
    step(1'b1, 16'h0008, "inj_w0");
    inj_req = 1'b0;
    chk("inj_w0_const", 32'(data_out), 32'h2077);
    chk("inj_cnt1", 32'(inj_cnt), 32'd1);
    step(1'b1, 16'h0, "inj_w1_clean");
    inj_req = 1'b1; inj_bit = 4'd5;
    step(1'b0, 16'h0, "inj_pend");
    inj_bit = 4'd9;
    step(1'b0, 16'h0, "inj_drop");
    inj_req = 1'b0;
    step(1'b1, 16'h0020, "inj_apply");
    chk("inj_cnt2", 32'(inj_cnt), 32'd2);
    step(1'b1, 16'h0, "inj_after_clean");
    inj_req = 1'b1; inj_bit = 4'd2;
    step(1'b0, 16'h0, "inj_pend2");
    inj_req = 1'b0;
    do_load(7'h7F);
    step(1'b1, 16'h0, "load_clears_pend");
    chk("inj_cnt_kept", 32'(inj_cnt), 32'd2);
    step(1'b1, 16'h0, "load_clears_pend2");
`endif

    // asynchronous reset in the middle of a RUN cycle
    step(1'b1, 16'h0, "pre_rst");
    #3 rstb = 1'b0;
    #1;
    chk("arst_data", 32'(data_out), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_cnt", 32'(inj_cnt), 32'd0);
    tick;
    rstb = 1'b1;
    last = '0;
    en = 1'b1;
    repeat (3) begin
      tick;
      chk("post_rst_valid", 32'(valid), 32'd0);
      chk("post_rst_data", 32'(data_out), 32'd0);
    end
    do_load(7'h7F);
    step(1'b1, 16'h0, "post_rst_w0");
    chk("post_rst_w0_const", 32'(data_out), 32'h207F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
